// File: rtl/xrouter_rr_pipe.sv
// xrouter_rr_pipe: NI-initiator x NT-target packet crossbar.
// Each target has its own round-robin arbiter, a lock that holds a
// multi-beat packet to one owner, and a single registered output slot
// (1-cycle latency, one beat per cycle per target).
// Optional feature macro: XROUTER_DROP_EN.
//   defined   -> beats with an out-of-range target tag are accepted and
//                discarded, and drop_cnt counts them (saturating).
//   undefined -> such beats are never granted and drop_cnt is 0.
// Handshake: a beat moves from initiator i when I_vld[i] & I_gnt[i].
// A beat leaves target j when T_vld[j] & T_rdy[j]. T_vld/T_pkt/T_last
// hold steady while T_vld[j] & !T_rdy[j].
module xrouter_rr_pipe #(
    parameter int NI      = 5,
    parameter int NT      = 3,
    parameter int VDW     = 37,
    parameter int TAG_LSB = 32,
    parameter int TW      = 2,
    parameter int CW      = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NI-1:0]     I_vld,
    input  logic [NI*VDW-1:0] I_pkt,
    input  logic [NI-1:0]     I_last,
    output logic [NI-1:0]     I_gnt,
    input  logic [NT-1:0]     T_rdy,
    output logic [NT-1:0]     T_vld,
    output logic [NT*VDW-1:0] T_pkt,
    output logic [NT-1:0]     T_last,
    output logic [CW-1:0]     drop_cnt
);

    localparam int PW = (NI > 1) ? $clog2(NI) : 1;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } lock_state_t;

    // Per-target state
    logic [NT-1:0]  r_vld;
    logic [NT-1:0]  r_last;
    logic [VDW-1:0] r_pkt   [NT];
    logic [PW-1:0]  r_ptr   [NT];
    lock_state_t    r_state [NT];
    logic [PW-1:0]  r_owner [NT];

    // Decode and arbitration results
    logic [TW-1:0]  w_tag      [NI];
    logic [NI-1:0]  w_req      [NT];
    logic [NI-1:0]  w_gnt      [NT];
    logic [PW-1:0]  w_win      [NT];
    logic [VDW-1:0] w_win_pkt  [NT];
    logic [NT-1:0]  w_win_last;
    logic [NT-1:0]  w_any;
    logic [NT-1:0]  w_load;
    logic [NT-1:0]  w_fire;

    // Extract the target tag from every initiator packet
    always_comb begin
        for (int i = 0; i < NI; i++) begin
            w_tag[i] = I_pkt[i*VDW + TAG_LSB +: TW];
        end
    end

`ifdef XROUTER_DROP_EN
    logic [NI-1:0] w_illegal;
    logic [CW:0]   w_drop_sum;
    logic [CW-1:0] r_drop_cnt;

    // Flag illegal-tag beats and sum them onto the running drop count
    always_comb begin
        w_illegal  = '0;
        w_drop_sum = {1'b0, r_drop_cnt};
        for (int i = 0; i < NI; i++) begin
            w_illegal[i] = I_vld[i] && (int'(w_tag[i]) >= NT);
            w_drop_sum   = w_drop_sum + (CW+1)'(w_illegal[i]);
        end
    end

    // Saturating drop counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_drop_cnt <= '0;
        end else if (w_drop_sum[CW]) begin
            r_drop_cnt <= '1;
        end else begin
            r_drop_cnt <= w_drop_sum[CW-1:0];
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = '0;
`endif

    // Per-target request masking, round-robin pick and load enable
    always_comb begin
        int idx;
        idx    = 0;
        w_any  = '0;
        w_load = '0;
        w_fire = '0;
        for (int j = 0; j < NT; j++) begin
            w_req[j] = '0;
            w_gnt[j] = '0;
            w_win[j] = '0;
            for (int i = 0; i < NI; i++) begin
                w_req[j][i] = I_vld[i] && (int'(w_tag[i]) == j);
            end
            // A locked target only listens to its owner
            if (r_state[j] == S_LOCKED) begin
                w_req[j] = w_req[j] & (NI'(1) << r_owner[j]);
            end
            w_load[j] = !r_vld[j] || T_rdy[j];
            for (int k = 0; k < NI; k++) begin
                idx = (int'(r_ptr[j]) + k) % NI;
                if (!w_any[j] && w_req[j][idx]) begin
                    w_any[j] = 1'b1;
                    w_win[j] = PW'(idx);
                end
            end
            w_fire[j] = w_any[j] && w_load[j];
            if (w_fire[j]) begin
                w_gnt[j][w_win[j]] = 1'b1;
            end
        end
    end

    // Select the winning beat for each target
    always_comb begin
        w_win_last = '0;
        for (int j = 0; j < NT; j++) begin
            w_win_pkt[j] = '0;
            for (int i = 0; i < NI; i++) begin
                if (w_win[j] == PW'(i)) begin
                    w_win_pkt[j]  = I_pkt[i*VDW +: VDW];
                    w_win_last[j] = I_last[i];
                end
            end
        end
    end

    // Merge per-target grants (and drops) into the initiator grant vector
    always_comb begin
        I_gnt = '0;
        for (int j = 0; j < NT; j++) begin
            I_gnt = I_gnt | w_gnt[j];
        end
`ifdef XROUTER_DROP_EN
        I_gnt = I_gnt | w_illegal;
`endif
    end

    // Output slots, RR pointers and lock FSM per target
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld  <= '0;
            r_last <= '0;
            for (int j = 0; j < NT; j++) begin
                r_pkt[j]   <= '0;
                r_ptr[j]   <= '0;
                r_state[j] <= S_IDLE;
                r_owner[j] <= '0;
            end
        end else begin
            for (int j = 0; j < NT; j++) begin
                if (w_fire[j]) begin
                    r_vld[j]  <= 1'b1;
                    r_pkt[j]  <= w_win_pkt[j];
                    r_last[j] <= w_win_last[j];
                    r_ptr[j]  <= (int'(w_win[j]) == NI-1) ? '0 : w_win[j] + PW'(1);
                    case (r_state[j])
                        S_IDLE: begin
                            if (!w_win_last[j]) begin
                                r_state[j] <= S_LOCKED;
                                r_owner[j] <= w_win[j];
                            end
                        end
                        S_LOCKED: begin
                            if (w_win_last[j]) begin
                                r_state[j] <= S_IDLE;
                            end
                        end
                        default: r_state[j] <= S_IDLE;
                    endcase
                end else if (T_rdy[j]) begin
                    r_vld[j] <= 1'b0;
                end
            end
        end
    end

    // Drive the packed target outputs from the slot registers
    always_comb begin
        T_pkt = '0;
        for (int j = 0; j < NT; j++) begin
            T_pkt[j*VDW +: VDW] = r_pkt[j];
        end
    end

    assign T_vld  = r_vld;
    assign T_last = r_last;

`ifndef SYNTHESIS
    genvar ga;
    for (ga = 0; ga < NT; ga++) begin : g_chk
        a_slot_tag: assert property (@(posedge clk) disable iff (!rstn)
            r_vld[ga] |-> (int'(r_pkt[ga][TAG_LSB +: TW]) == ga));
        a_lock_tag: assert property (@(posedge clk) disable iff (!rstn)
            ((r_state[ga] == S_LOCKED) && I_vld[r_owner[ga]]) |-> (int'(w_tag[r_owner[ga]]) == ga));
        a_gnt_onehot: assert property (@(posedge clk) disable iff (!rstn)
            $onehot0(w_gnt[ga]));
    end
`endif

endmodule
